// File: rtl/alu_md_seq.sv
// alu_md_seq: handshaked single-issue ALU with an optional radix-2 multiply/divide unit.
// Define ALU_MULDIV_EN to build the M-extension datapath; without it every op[4]=1 is illegal.
module alu_md_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] da,
    input  logic [XLEN-1:0] db,
    input  logic [4:0]      op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] base_res;
    logic            base_ill;
    logic [SW-1:0]   shamt;
    logic            accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign shamt     = db[SW-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (op[3:0])
            4'd0:    base_res = da + db;
            4'd1:    base_res = da - db;
            4'd2:    base_res = da << shamt;
            4'd3:    base_res = {{(XLEN-1){1'b0}}, ($signed(da) < $signed(db))};
            4'd4:    base_res = {{(XLEN-1){1'b0}}, (da < db)};
            4'd5:    base_res = da ^ db;
            4'd6:    base_res = da >> shamt;
            4'd7:    base_res = $signed(da) >>> shamt;
            4'd8:    base_res = da | db;
            4'd9:    base_res = da & db;
            4'd10:   base_res = db;
            default: base_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic [2:0]        mop_q, mop_d;
    logic [XLEN-1:0]   abs_a, abs_b, pre_a, pre_b;
    logic              pre_neg;
    logic              md_special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [XLEN-1:0]   step_hi, step_lo, md_raw, md_res;
    logic [2*XLEN-1:0] prod;

    // Signed ops run on magnitudes; neg records whether the final value must be negated.
    always_comb begin
        abs_a       = da[XLEN-1] ? -da : da;
        abs_b       = db[XLEN-1] ? -db : db;
        pre_a       = da;
        pre_b       = db;
        pre_neg     = 1'b0;
        md_special  = 1'b0;
        special_res = '0;
        case (op[2:0])
            3'd1, 3'd4: begin
                pre_a   = abs_a;
                pre_b   = abs_b;
                pre_neg = da[XLEN-1] ^ db[XLEN-1];
            end
            3'd2: begin
                pre_a   = abs_a;
                pre_neg = da[XLEN-1];
            end
            3'd6: begin
                pre_a   = abs_a;
                pre_b   = abs_b;
                pre_neg = da[XLEN-1];
            end
            default: ;
        endcase
        if (op[2] && (db == '0)) begin
            md_special  = 1'b1;
            special_res = op[1] ? da : '1;
        end else if (op[2] && !op[0] && (da == {1'b1, {(XLEN-1){1'b0}}}) && (db == '1)) begin
            md_special  = 1'b1;
            special_res = op[1] ? '0 : da;
        end
    end

    // One shift-add (multiply) or restoring-subtract (divide) step per BUSY cycle.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        rem_sh  = {acc_hi_q, acc_lo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, opb_q};
        if (!mop_q[2]) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            step_hi = diff[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
        end else begin
            step_hi = rem_sh[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
        end
        prod   = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        md_raw = mop_q[1] ? step_hi : step_lo;
        case (mop_q)
            3'd0:             md_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: md_res = prod[2*XLEN-1:XLEN];
            default:          md_res = neg_q ? -md_raw : md_raw;
        endcase
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
`ifdef ALU_MULDIV_EN
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        mop_d     = mop_q;
`endif
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                BUSY: begin
`ifdef ALU_MULDIV_EN
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d   = DONE;
                        result_d  = md_res;
                        zero_d    = (md_res == '0);
                        illegal_d = 1'b0;
                        cnt_d     = '0;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    if ((state_q == DONE) && out_ready) begin
                        state_d = IDLE;
                    end
                    if (accept) begin
                        state_d   = DONE;
                        illegal_d = 1'b0;
                        if (!op[4]) begin
                            result_d  = base_res;
                            illegal_d = base_ill;
`ifdef ALU_MULDIV_EN
                        end else if (op[3]) begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end else if (md_special) begin
                            result_d = special_res;
                        end else begin
                            state_d  = BUSY;
                            acc_hi_d = '0;
                            acc_lo_d = pre_a;
                            opb_d    = pre_b;
                            neg_d    = pre_neg;
                            mop_d    = op[2:0];
                            cnt_d    = '0;
`else
                        end else begin
                            result_d  = '0;
                            illegal_d = 1'b1;
`endif
                        end
                        zero_d = (result_d == '0);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
`ifdef ALU_MULDIV_EN
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            mop_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
`ifdef ALU_MULDIV_EN
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            mop_q     <= mop_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_md_seq.sv
// tb_alu_md_seq: directed self-checking bench for alu_md_seq (XLEN=32).
// Multiply/divide expectations follow ALU_MULDIV_EN: real results when defined, illegal otherwise.
module tb_alu_md_seq;
    localparam int XLEN = 32;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_BAD    = 5'd11;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;
    localparam logic [4:0] OP_MBAD   = 5'd24;

    logic            clk, rst_n, in_valid, in_ready, flush;
    logic            out_valid, out_ready, zero, illegal;
    logic [XLEN-1:0] da, db, result;
    logic [4:0]      op;
    int              checks = 0;
    int              failures = 0;
    int              seen;

    alu_md_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .da(da), .db(db), .op(op), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operation for a single edge; caller ensures the block is ready.
    task automatic applyStimulus(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        op = o;
        da = a;
        db = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input int expCycles, input logic [XLEN-1:0] r, input logic il);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, ".latency"}, 64'(n), 64'(expCycles));
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ".result"}, 64'(result), 64'(r));
        checkOutput({tag, ".zero"}, 64'(zero), 64'(r == '0));
        checkOutput({tag, ".illegal"}, 64'(illegal), 64'(il));
    endtask

    task automatic drainOutput(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        da = '0; db = '0; op = '0;
        #2;
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
        checkOutput("reset.zero", 64'(zero), 64'd0);
        checkOutput("reset.illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset.in_ready", 64'(in_ready), 64'd1);

        applyStimulus(OP_SUB, 32'd5, 32'd5);
        expectResult("sub_eq", 0, 32'h0, 1'b0);
        drainOutput("sub_eq");
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        expectResult("add_ovf", 0, 32'h8000_0000, 1'b0);
        drainOutput("add_ovf");
        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        expectResult("slt", 0, 32'd1, 1'b0);
        drainOutput("slt");
        applyStimulus(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        expectResult("sltu", 0, 32'd0, 1'b0);
        drainOutput("sltu");
        applyStimulus(OP_SLL, 32'd1, 32'h21);
        expectResult("sll_mask", 0, 32'd2, 1'b0);
        drainOutput("sll_mask");
        applyStimulus(OP_SRL, 32'h8000_0000, 32'd4);
        expectResult("srl", 0, 32'h0800_0000, 1'b0);
        drainOutput("srl");
        applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expectResult("xor", 0, 32'h0FF0_0FF0, 1'b0);
        drainOutput("xor");
        applyStimulus(OP_OR, 32'hF000_0000, 32'h0000_000F);
        expectResult("or", 0, 32'hF000_000F, 1'b0);
        drainOutput("or");
        applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expectResult("and", 0, 32'hF000_F000, 1'b0);
        drainOutput("and");
        applyStimulus(OP_PASSB, 32'hDEAD_BEEF, 32'h0000_1234);
        expectResult("passb", 0, 32'h0000_1234, 1'b0);
        drainOutput("passb");
        applyStimulus(OP_BAD, 32'd9, 32'd9);
        expectResult("bad_op", 0, 32'h0, 1'b1);
        drainOutput("bad_op");

        applyStimulus(OP_SRA, 32'h8000_0000, 32'd4);
        expectResult("sra", 0, 32'hF800_0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("sra_hold.result", 64'(result), 64'(32'hF800_0000));
            checkOutput("sra_hold.out_valid", 64'(out_valid), 64'd1);
            checkOutput("sra_hold.in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("sra_release.in_ready", 64'(in_ready), 64'd1);
        op = OP_ADD; da = 32'd2; db = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        expectResult("b2b_add", 0, 32'd5, 1'b0);
        drainOutput("b2b_add");

        op = OP_ADD; da = 32'd1; db = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_override.out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_override.in_ready", 64'(in_ready), 64'd1);
        applyStimulus(OP_ADD, 32'd1, 32'd1);
        expectResult("pre_flush", 0, 32'd2, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_done.out_valid", 64'(out_valid), 64'd0);

        applyStimulus(OP_ADD, 32'd4, 32'd4);
        expectResult("pre_reset", 0, 32'd8, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset.result", 64'(result), 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef ALU_MULDIV_EN
        applyStimulus(OP_MULH, 32'h8000_0000, 32'h8000_0000);
        expectResult("mulh", XLEN, 32'h4000_0000, 1'b0);
        drainOutput("mulh");
        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'd3);
        expectResult("mul", XLEN, 32'hFFFF_FFFD, 1'b0);
        drainOutput("mul");
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expectResult("mulhu", XLEN, 32'hFFFF_FFFE, 1'b0);
        drainOutput("mulhu");
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
        expectResult("mulhsu", XLEN, 32'hFFFF_FFFF, 1'b0);
        drainOutput("mulhsu");
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expectResult("div_ovf", 0, 32'h8000_0000, 1'b0);
        drainOutput("div_ovf");
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        expectResult("rem_ovf", 0, 32'h0, 1'b0);
        drainOutput("rem_ovf");
        applyStimulus(OP_DIVU, 32'd7, 32'd0);
        expectResult("divu_zero", 0, 32'hFFFF_FFFF, 1'b0);
        drainOutput("divu_zero");
        applyStimulus(OP_REMU, 32'd7, 32'd0);
        expectResult("remu_zero", 0, 32'd7, 1'b0);
        drainOutput("remu_zero");

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("busy_flush.out_valid", 64'(out_valid), 64'd0);
        checkOutput("busy_flush.in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("busy_flush.no_output", 64'(seen), 64'd0);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        op = OP_ADD; da = '0; db = '0;
        expectResult("div_neg", XLEN, 32'hFFFF_FFFD, 1'b0);
        drainOutput("div_neg");
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2);
        expectResult("rem_neg", XLEN, 32'hFFFF_FFFF, 1'b0);
        drainOutput("rem_neg");
        applyStimulus(OP_MBAD, 32'd3, 32'd3);
        expectResult("m_bad", 0, 32'h0, 1'b1);
        drainOutput("m_bad");

        applyStimulus(OP_MUL, 32'd3, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_reset.in_ready_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("busy_reset.out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("busy_reset.no_output", 64'(seen), 64'd0);
        checkOutput("busy_reset.in_ready", 64'(in_ready), 64'd1);
`else
        applyStimulus(OP_MULH, 32'h8000_0000, 32'h8000_0000);
        expectResult("mulh_off", 0, 32'h0, 1'b1);
        drainOutput("mulh_off");
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expectResult("div_off", 0, 32'h0, 1'b1);
        drainOutput("div_off");
        applyStimulus(OP_DIVU, 32'd7, 32'd0);
        expectResult("divu_off", 0, 32'h0, 1'b1);
        drainOutput("divu_off");
        applyStimulus(OP_REMU, 32'd7, 32'd3);
        expectResult("remu_off", 0, 32'h0, 1'b1);
        checkOutput("remu_off.in_ready", 64'(in_ready), 64'd0);
        drainOutput("remu_off");
        checkOutput("off.in_ready", 64'(in_ready), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_md_seq.md
ALU_MD_SEQ -- requirements
Module: alu_md_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 32, 64).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1  operand/op offer; in_ready  out  1  block can accept.
REQ-005 SHALL have ports: da, db  in  XLEN  operands; op  in  5  operation select.
REQ-006 SHALL have ports: flush  in  1  synchronous abort of any in-flight operation.
REQ-007 SHALL have ports: out_valid  out  1; out_ready  in  1; result  out  XLEN; zero  out  1  (result==0); illegal  out  1  (op not supported).

Function
REQ-008 SHALL decode op[4]=0 base ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB; 11-15 give result 0 with illegal=1.
REQ-009 SHALL decode op[4]=1 as M-extension, op[2:0]=funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; op[3]=1 with op[4]=1 -> illegal=1, result 0.
REQ-010 SHALL take shift amount from db[log2(XLEN)-1:0]; SLT/SLTU produce 1 or 0 zero-extended.
REQ-011 SHALL use states IDLE, BUSY, DONE; transfer occurs on in_valid&&in_ready, output handshake on out_valid&&out_ready.
REQ-012 SHALL assert in_ready in IDLE, and in DONE when out_ready=1 (back-to-back accept); never in BUSY.
REQ-013 SHALL complete base ops, illegal ops and divide special cases in one cycle: accepted at edge T -> DONE, out_valid=1 after edge T+1's preceding edge (visible in cycle T+1).
REQ-014 SHALL execute MUL*/DIV*/REM* by radix-2 iteration, exactly XLEN cycles in BUSY; out_valid visible XLEN+1 cycles after acceptance.
REQ-015 SHALL return low XLEN bits for MUL, high XLEN bits of the signed*signed, signed*unsigned, unsigned*unsigned 2XLEN product for MULH/MULHSU/MULHU.
REQ-016 SHALL on divisor 0: quotient all-ones, remainder = da (signed and unsigned).
REQ-017 SHALL on signed overflow (da = most-negative, db = -1): DIV result = da, REM result 0.
REQ-018 SHALL give remainder the sign of dividend, quotient truncated toward zero.
REQ-019 SHALL hold result, zero, illegal stable while out_valid=1 and out_ready=0.
REQ-020 SHALL on flush=1: go to IDLE at next edge, drop out_valid, discard in-flight op; flush overrides a simultaneous in_valid (no accept that cycle).
REQ-021 SHALL ignore da/db/op changes while BUSY (operands latched at acceptance).

Reset
REQ-022 SHALL on rst_n=0, asynchronously: state IDLE, out_valid 0, result 0, zero 0, illegal 0, iteration counter 0; in_ready 1 once rst_n=1.
REQ-023 SHALL abandon any in-flight operation on reset assertion with no output produced.

Configuration
REQ-024 SHALL compile the multiply/divide unit only when macro ALU_MULDIV_EN is defined.
REQ-025 SHALL, with ALU_MULDIV_EN undefined, treat every op[4]=1 as illegal: one-cycle, result 0, illegal=1, zero=1; no BUSY state reachable.

Verification
REQ-026 SHALL check: XLEN=32, op=SUB, da=5, db=5 -> next cycle out_valid=1, result=0, zero=1.
REQ-027 SHALL check: op=MULH, da=0x80000000, db=0x80000000 -> after 33 cycles result=0x40000000, zero=0.
REQ-028 SHALL check: op=DIV, da=0x80000000, db=0xFFFFFFFF -> 1 cycle, result=0x80000000; op=REM same operands -> 0.
REQ-029 SHALL check: op=DIVU, da=7, db=0 -> result=0xFFFFFFFF; op=REMU -> 7.
REQ-030 SHALL check: op=DIV, da=-7, db=2, flush pulsed in BUSY cycle 10 -> no out_valid; then reissue -> result=-3; REM -> -1.
REQ-031 SHALL check: out_ready held 0 for 5 cycles after SRA da=0x80000000 db=4 -> result 0xF8000000 stable, in_ready=0 until out_ready=1.
